// File: rtl/mem_dump_tx.sv
// mem_dump_tx: captures the data-memory snapshot bus on a start pulse and
// sends it out one byte per valid/ready transfer. Word 0 goes first, and each
// word is sent most significant byte first.
// Optional build macro: MEM_DUMP_CHECKSUM_EN. When it is defined, one more
// byte follows the data: the XOR of all data bytes.
//
// Handshake: a byte moves at a rising edge where tx_valid && tx_ready.
// While tx_valid=1 and tx_ready=0, tx_data and tx_valid stay stable.
// tx_valid drops only after a transfer or on reset.
module mem_dump_tx #(
    parameter int NUM_WORDS  = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                            clka,
    input  logic                            reset,
    input  logic                            start,
    input  logic [NUM_WORDS*DATA_WIDTH-1:0] memorias,
    input  logic                            tx_ready,
    output logic [7:0]                      tx_data,
    output logic                            tx_valid,
    output logic                            busy,
    output logic                            done
);

    localparam int TOTAL_W = NUM_WORDS * DATA_WIDTH;
    localparam int N_BYTES = TOTAL_W / 8;
    // Sized for N+1 so that the checksum byte index also fits.
    localparam int CNT_W   = $clog2(N_BYTES + 2);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(N_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [TOTAL_W-1:0] r_snap;
    logic [CNT_W-1:0]   r_cnt;
    logic [7:0]         r_tx_data;
    logic               r_tx_valid;
    logic               r_busy;
    logic               r_done;
`ifdef MEM_DUMP_CHECKSUM_EN
    logic [7:0]         r_csum;
`endif

    logic               w_xfer;
    logic [CNT_W-1:0]   w_next_idx;
    logic [TOTAL_W-1:0] w_shifted;
    logic [7:0]         w_next_byte;

    // The flat bus is already in transmit order, because word 0 sits in the
    // MSBs and is big-endian. Byte b is therefore the top byte after a left
    // shift of 8*b.
    always_comb begin
        w_xfer      = r_tx_valid & tx_ready;
        w_next_idx  = r_cnt + 1'b1;
        w_shifted   = r_snap << {w_next_idx, 3'b000};
        w_next_byte = w_shifted[TOTAL_W-1 -: 8];
    end

    // Dump FSM. All outputs are registered, so reset clears them immediately.
    always_ff @(posedge clka or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_snap     <= '0;
            r_cnt      <= '0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
            r_csum     <= 8'h00;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_snap     <= memorias;
                        r_cnt      <= '0;
                        r_tx_data  <= memorias[TOTAL_W-1 -: 8];
                        r_tx_valid <= 1'b1;
                        r_busy     <= 1'b1;
`ifdef MEM_DUMP_CHECKSUM_EN
                        r_csum     <= 8'h00;
`endif
                        r_state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_xfer) begin
                        if (r_cnt < LAST_DATA) begin
                            r_cnt     <= w_next_idx;
                            r_tx_data <= w_next_byte;
`ifdef MEM_DUMP_CHECKSUM_EN
                            r_csum    <= r_csum ^ r_tx_data;
`endif
                        end
`ifdef MEM_DUMP_CHECKSUM_EN
                        else if (r_cnt == LAST_DATA) begin
                            // Fold in the last data byte as it leaves.
                            // The total then goes out as one more byte.
                            r_cnt     <= w_next_idx;
                            r_tx_data <= r_csum ^ r_tx_data;
                        end else begin
                            r_tx_valid <= 1'b0;
                            r_tx_data  <= 8'h00;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_state    <= S_DONE;
                        end
`else
                        else begin
                            r_tx_valid <= 1'b0;
                            r_tx_data  <= 8'h00;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_state    <= S_DONE;
                        end
`endif
                    end
                end
                S_DONE: begin
                    // done lasts one cycle. start is not looked at here.
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
